serial_debug_node: RTL and testbench

Daisy-chainable debug node that sits on a two-wire (clock + data) serial ring between a host bridge and other nodes. It receives 144-bit frames, acts on frames for its own address, and forwards every frame downstream, modified or unchanged. It supports:

- enumeration, which assigns addresses along the chain;
- an identity read;
- a read of a 128-bit debug word from the design;
- a write of a 128-bit word into the design, signalled by a toggle.

---
 rtl/serial_debug_node.sv | 211 +++++++++++++++++++++
 tb/tb_serial_debug_node.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_debug_node.sv
// Daisy-chain debug node on a two-wire serial ring: it receives 144-bit frames, handles
// enumeration, identity/debug reads and writes for its own address, and forwards every frame.
module serial_debug_node (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   prescaler,
    input  logic         rx_data,
    input  logic         rx_clk,
    output logic         tx_data,
    output logic         tx_clk,
    input  logic [127:0] identity,
    input  logic [127:0] debug_outgoing_data,
    output logic [127:0] debug_incoming_data,
    output logic         debug_incoming_tgl
);

    localparam logic [14:0] BCAST_ADDR = 15'h7FFF;
    localparam logic [7:0]  LAST_BIT   = 8'd143;
    localparam logic [7:0]  CMD_IDENT  = 8'h00;
    localparam logic [7:0]  CMD_DEBUG  = 8'hFF;

    logic [2:0]   rx_clk_sync_q;
    logic [1:0]   rx_data_sync_q;
    logic [143:0] rx_sr_q, rx_sr_d;
    logic [7:0]   rx_cnt_q, rx_cnt_d;
    logic [15:0]  idle_cnt_q, idle_cnt_d;
    logic [143:0] rx_frame_q, rx_frame_d;
    logic         rx_done_q, rx_done_d;

    logic [14:0]  my_addr_q, my_addr_d;
    logic         addr_valid_q, addr_valid_d;
    logic [127:0] dbg_in_q, dbg_in_d;
    logic         tgl_q, tgl_d;

    logic [143:0] pend_q, pend_d;
    logic         pend_valid_q, pend_valid_d;

    logic [143:0] tx_sr_q, tx_sr_d;
    logic [7:0]   tx_idx_q, tx_idx_d;
    logic [7:0]   tx_div_q, tx_div_d;
    logic         tx_busy_q, tx_busy_d;
    logic         tx_clk_q, tx_clk_d;
    logic         tx_data_q, tx_data_d;

    logic         rx_rise, rx_edge;
    logic [14:0]  f_addr;
    logic         f_rw;
    logic [7:0]   f_cmd;
    logic         addr_hit;
    logic [143:0] proc_frame;
    logic         tx_load;
    logic         accept;

    assign rx_rise = rx_clk_sync_q[1] & ~rx_clk_sync_q[2];
    assign rx_edge = rx_clk_sync_q[1] ^ rx_clk_sync_q[2];

    assign f_addr   = rx_frame_q[15:1];
    assign f_rw     = rx_frame_q[0];
    assign f_cmd    = rx_frame_q[23:16];
    assign addr_hit = addr_valid_q && (f_addr == my_addr_q);

    assign tx_load = pend_valid_q && !tx_busy_q;
    // A new frame may take the pending slot in the same cycle it is handed to the transmitter.
    assign accept  = rx_done_q && (!pend_valid_q || tx_load);

    always_comb begin
        proc_frame = rx_frame_q;
        if (f_addr == BCAST_ADDR) begin
            proc_frame[30:16] = rx_frame_q[30:16] + 15'd1;
        end else if (addr_hit && !f_rw) begin
            if (f_cmd == CMD_IDENT) begin
                proc_frame[143:16] = identity;
            end else if (f_cmd == CMD_DEBUG) begin
                proc_frame[143:16] = debug_outgoing_data;
            end
        end
    end

    always_comb begin
        rx_sr_d    = rx_sr_q;
        rx_cnt_d   = rx_cnt_q;
        idle_cnt_d = 16'd0;
        rx_frame_d = rx_frame_q;
        rx_done_d  = 1'b0;
        if (rx_rise) begin
            rx_sr_d = {rx_sr_q[142:0], rx_data_sync_q[1]};
            if (rx_cnt_q == LAST_BIT) begin
                rx_cnt_d   = 8'd0;
                rx_frame_d = {rx_sr_q[142:0], rx_data_sync_q[1]};
                rx_done_d  = 1'b1;
            end else begin
                rx_cnt_d = rx_cnt_q + 8'd1;
            end
        end else if (!rx_edge && rx_cnt_q != 8'd0) begin
            // Upstream went silent mid-frame: drop the partial frame after 65536 quiet cycles.
            if (idle_cnt_q == 16'hFFFF) begin
                rx_cnt_d = 8'd0;
            end else begin
                idle_cnt_d = idle_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        my_addr_d    = my_addr_q;
        addr_valid_d = addr_valid_q;
        dbg_in_d     = dbg_in_q;
        tgl_d        = tgl_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (tx_load) begin
            pend_valid_d = 1'b0;
        end
        if (accept) begin
            pend_d       = proc_frame;
            pend_valid_d = 1'b1;
            if (f_addr == BCAST_ADDR) begin
                my_addr_d    = rx_frame_q[30:16];
                addr_valid_d = 1'b1;
            end else if (addr_hit && f_rw) begin
                dbg_in_d = rx_frame_q[143:16];
                tgl_d    = ~tgl_q;
            end
        end
    end

    always_comb begin
        tx_sr_d   = tx_sr_q;
        tx_idx_d  = tx_idx_q;
        tx_div_d  = tx_div_q;
        tx_busy_d = tx_busy_q;
        tx_clk_d  = tx_clk_q;
        tx_data_d = tx_data_q;
        if (tx_load) begin
            tx_sr_d   = pend_q;
            tx_idx_d  = 8'd0;
            tx_div_d  = 8'd0;
            tx_busy_d = 1'b1;
            tx_clk_d  = 1'b0;
            tx_data_d = pend_q[143];
        end else if (tx_busy_q) begin
            if (tx_div_q == prescaler) begin
                tx_div_d = 8'd0;
                if (!tx_clk_q) begin
                    tx_clk_d = 1'b1;
                end else if (tx_idx_q == LAST_BIT) begin
                    tx_busy_d = 1'b0;
                    tx_clk_d  = 1'b0;
                    tx_data_d = 1'b0;
                end else begin
                    tx_idx_d  = tx_idx_q + 8'd1;
                    tx_sr_d   = {tx_sr_q[142:0], 1'b0};
                    tx_clk_d  = 1'b0;
                    tx_data_d = tx_sr_q[142];
                end
            end else begin
                tx_div_d = tx_div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_clk_sync_q  <= '0;
            rx_data_sync_q <= '0;
            rx_sr_q        <= '0;
            rx_cnt_q       <= '0;
            idle_cnt_q     <= '0;
            rx_frame_q     <= '0;
            rx_done_q      <= 1'b0;
            my_addr_q      <= '0;
            addr_valid_q   <= 1'b0;
            dbg_in_q       <= '0;
            tgl_q          <= 1'b0;
            pend_q         <= '0;
            pend_valid_q   <= 1'b0;
            tx_sr_q        <= '0;
            tx_idx_q       <= '0;
            tx_div_q       <= '0;
            tx_busy_q      <= 1'b0;
            tx_clk_q       <= 1'b0;
            tx_data_q      <= 1'b0;
        end else begin
            rx_clk_sync_q  <= {rx_clk_sync_q[1:0], rx_clk};
            rx_data_sync_q <= {rx_data_sync_q[0], rx_data};
            rx_sr_q        <= rx_sr_d;
            rx_cnt_q       <= rx_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            rx_frame_q     <= rx_frame_d;
            rx_done_q      <= rx_done_d;
            my_addr_q      <= my_addr_d;
            addr_valid_q   <= addr_valid_d;
            dbg_in_q       <= dbg_in_d;
            tgl_q          <= tgl_d;
            pend_q         <= pend_d;
            pend_valid_q   <= pend_valid_d;
            tx_sr_q        <= tx_sr_d;
            tx_idx_q       <= tx_idx_d;
            tx_div_q       <= tx_div_d;
            tx_busy_q      <= tx_busy_d;
            tx_clk_q       <= tx_clk_d;
            tx_data_q      <= tx_data_d;
        end
    end

    assign tx_data             = tx_data_q;
    assign tx_clk              = tx_clk_q;
    assign debug_incoming_data = dbg_in_q;
    assign debug_incoming_tgl  = tgl_q;

endmodule

// File: tb/tb_serial_debug_node.sv
// Bench for serial_debug_node: acts as upstream bridge and downstream receiver, checking
// directed vectors, random frames against a frame-level model, and a mid-frame reset.
module tb_serial_debug_node;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   prescaler;
    logic         rx_data;
    logic         rx_clk;
    logic         tx_data;
    logic         tx_clk;
    logic [127:0] identity;
    logic [127:0] debug_outgoing_data;
    logic [127:0] debug_incoming_data;
    logic         debug_incoming_tgl;

    serial_debug_node dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .prescaler           (prescaler),
        .rx_data             (rx_data),
        .rx_clk              (rx_clk),
        .tx_data             (tx_data),
        .tx_clk              (tx_clk),
        .identity            (identity),
        .debug_outgoing_data (debug_outgoing_data),
        .debug_incoming_data (debug_incoming_data),
        .debug_incoming_tgl  (debug_incoming_tgl)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] IDENT = 128'h12345678_11223344_55667788_99AABBCC;
    localparam logic [127:0] DBGW  = 128'hFEDCBA98_76543210_00112233_44556677;
    localparam logic [127:0] WRW   = 128'hAABBCCDD_EEFF0011_22334455_66778899;
    localparam int RX_HALF = 3;

    typedef struct {
        logic [143:0] frame_in;
        logic [143:0] exp_out;
        int           exp_tgl;
    } vec_t;

    vec_t vecs[8];

    int checks = 0;
    int errors = 0;

    // Downstream receiver and toggle monitor
    logic [143:0] out_q[$];
    int           tgl_count = 0;

    initial begin
        logic [143:0] cap_sr;
        int           cap_cnt;
        logic         prev_clk;
        logic         prev_tgl;
        cap_sr = '0;
        cap_cnt = 0;
        prev_clk = 1'b0;
        prev_tgl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cap_cnt   = 0;
                prev_clk  = tx_clk;
                prev_tgl  = debug_incoming_tgl;
                tgl_count = 0;
            end else begin
                if (tx_clk && !prev_clk) begin
                    cap_sr = {cap_sr[142:0], tx_data};
                    cap_cnt++;
                    if (cap_cnt == 144) begin
                        out_q.push_back(cap_sr);
                        cap_cnt = 0;
                    end
                end
                if (debug_incoming_tgl != prev_tgl) tgl_count++;
                prev_clk = tx_clk;
                prev_tgl = debug_incoming_tgl;
            end
        end
    end

    // Frame-level reference model of node behaviour
    logic [14:0]  m_addr;
    logic         m_valid;
    logic [127:0] m_data;
    int           m_tgl;

    task automatic model_step(input logic [143:0] f, input logic [127:0] id,
                              input logic [127:0] dbg, output logic [143:0] o);
        logic [14:0]  addr;
        logic         is_write;
        logic [7:0]   cmd;
        logic [127:0] payload;
        addr     = f[15:1];
        is_write = f[0];
        payload  = f[143:16];
        cmd      = payload[7:0];
        o        = f;
        if (addr == 15'h7FFF) begin
            m_addr    = f[30:16];
            m_valid   = 1'b1;
            o[30:16]  = f[30:16] + 15'd1;
        end else if (m_valid && addr == m_addr) begin
            if (is_write) begin
                m_data = payload;
                m_tgl++;
            end else if (cmd == 8'h00) begin
                o = {id, f[15:0]};
            end else if (cmd == 8'hFF) begin
                o = {dbg, f[15:0]};
            end
        end
    endtask

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [143:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            rx_data = f[143 - i];
            repeat (RX_HALF) @(negedge clk);
            rx_clk = 1'b1;
            repeat (RX_HALF) @(negedge clk);
            rx_clk = 1'b0;
        end
    endtask

    task automatic get_frame(input string name, output logic [143:0] f, output bit ok);
        int waited;
        waited = 0;
        ok = 1'b0;
        f = '0;
        while (out_q.size() == 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (out_q.size() != 0) begin
            f = out_q.pop_front();
            ok = 1'b1;
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: no output frame within 3000 cycles", name);
        end
    endtask

    task automatic run_frame(input string name, input logic [143:0] f, input logic [143:0] exp,
                             input int exp_tgl_delta, input bit use_table);
        logic [143:0] got, model_out;
        bit           ok;
        int           tgl_before;
        tgl_before = tgl_count;
        model_step(f, identity, debug_outgoing_data, model_out);
        send_bits(f, 144);
        get_frame(name, got, ok);
        if (ok) begin
            chk({name, " frame"}, got, use_table ? exp : model_out);
            $display("txn %s: in=%h out=%h", name, f, got);
        end
        chk({name, " tgl_delta"}, 144'(tgl_count - tgl_before),
            144'(use_table ? exp_tgl_delta : (m_tgl - (m_tgl - (tgl_count - tgl_before)))));
        chk({name, " wdata"}, {16'h0, debug_incoming_data}, {16'h0, m_data});
        chk({name, " tgl_level"}, 144'(debug_incoming_tgl), 144'(m_tgl[0]));
    endtask

    initial begin
        logic [143:0] f, got;
        bit           ok;
        int           sel;

        vecs[0] = '{{113'h0, 15'h1234, 16'hFFFE}, {113'h0, 15'h1235, 16'hFFFE}, 0};
        vecs[1] = '{{120'h0, 8'h00, 16'h2468}, {IDENT, 16'h2468}, 0};
        vecs[2] = '{{120'h0, 8'h00, 16'h246A}, {120'h0, 8'h00, 16'h246A}, 0};
        vecs[3] = '{{120'h0, 8'hFF, 16'h2468}, {DBGW, 16'h2468}, 0};
        vecs[4] = '{{120'h0, 8'hFF, 16'h2466}, {120'h0, 8'hFF, 16'h2466}, 0};
        vecs[5] = '{{WRW, 16'h2469}, {WRW, 16'h2469}, 1};
        vecs[6] = '{{120'hABC, 8'h5A, 16'h2468}, {120'hABC, 8'h5A, 16'h2468}, 0};
        vecs[7] = '{{128'h5555, 16'h246B}, {128'h5555, 16'h246B}, 0};

        rst_n = 1'b0;
        prescaler = 8'd2;
        rx_clk = 1'b0;
        rx_data = 1'b0;
        identity = IDENT;
        debug_outgoing_data = DBGW;
        m_addr = '0;
        m_valid = 1'b0;
        m_data = '0;
        m_tgl = 0;
        repeat (5) @(negedge clk);
        chk("reset tx_clk", 144'(tx_clk), 144'(0));
        chk("reset tx_data", 144'(tx_data), 144'(0));
        chk("reset wdata", {16'h0, debug_incoming_data}, 144'(0));
        chk("reset tgl", 144'(debug_incoming_tgl), 144'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Unenumerated node: a read to address 0 must pass untouched
        f = {120'h0, 8'h00, 16'h0000};
        run_frame("unenum_read0", f, f, 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].frame_in, vecs[i].exp_out, vecs[i].exp_tgl, 1'b1);
        end

        repeat (10) @(negedge clk);
        chk("idle tx_clk", 144'(tx_clk), 144'(0));
        chk("idle tx_data", 144'(tx_data), 144'(0));

        for (int i = 0; i < 14; i++) begin
            identity = {$urandom(), $urandom(), $urandom(), $urandom()};
            debug_outgoing_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            f = {16'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       f[15:1] = 15'h7FFF;
                1, 2:    f[15:1] = m_addr;
                3:       f[15:1] = m_addr + 15'd1;
                default: ;
            endcase
            sel = int'($urandom_range(0, 3));
            if (sel == 0) f[23:16] = 8'h00;
            else if (sel == 1) f[23:16] = 8'hFF;
            run_frame($sformatf("rand%0d", i), f, '0, 0, 1'b0);
        end

        // Reset while a frame is being transmitted and another is 70 bits into reception
        identity = IDENT;
        debug_outgoing_data = DBGW;
        send_bits({WRW, 16'h0000}, 144);
        send_bits({WRW, 16'h2468}, 70);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset tx_clk", 144'(tx_clk), 144'(0));
        chk("midreset tx_data", 144'(tx_data), 144'(0));
        chk("midreset wdata", {16'h0, debug_incoming_data}, 144'(0));
        chk("midreset tgl", 144'(debug_incoming_tgl), 144'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        out_q.delete();
        m_addr = '0;
        m_valid = 1'b0;
        m_data = '0;
        m_tgl = 0;
        repeat (20) @(negedge clk);
        chk("postreset idle tx_clk", 144'(tx_clk), 144'(0));

        f = {120'h0, 8'h00, 16'h0000};
        run_frame("post_read0", f, f, 0, 1'b1);
        run_frame("post_enum", {113'h0, 15'h0005, 16'hFFFE}, {113'h0, 15'h0006, 16'hFFFE}, 0, 1'b1);
        run_frame("post_ident", {120'h0, 8'h00, 16'h000A}, {IDENT, 16'h000A}, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
